// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Handshake and operand/result bundle for the bit-serial adder/subtractor.
//   master : requester side, drives start/mode/a/b, observes status/results.
//   slave  : the serial_addsub core, consumes the request, drives results.
//
//   start    request pulse (sampled only while the core is idle)
//   mode     0 = a + b, 1 = a - b (sampled with start)
//   a, b     WIDTH-bit operands (sampled with start)
//   busy     high while the core is shifting bits
//   done     one-cycle completion pulse
//   sum      WIDTH-bit result, held until the next completion
//   cout     carry out (for subtract: 1 means no borrow)
//   overflow signed overflow of the last operation
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder/subtractor: one full-adder cell plus a registered carry
//   processes WIDTH bits LSB first, one bit per clock.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_addsub_if.slave (start/mode/a/b in, busy/done/sum/cout/
//            overflow out, all outputs registered)
//
//   Timing: start accepted at edge k -> busy for WIDTH cycles -> done pulse in
//   the cycle after edge k+WIDTH -> back in IDLE one cycle later.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    // Single full-adder cell working on the current LSBs.
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] acc_nxt;

    always_comb begin
        s_bit   = sa[0] ^ sb[0] ^ c;
        c_nxt   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        acc_nxt = {s_bit, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        // Subtract as a + ~b + 1: invert b and seed the carry with 1.
                        sb     <= bus.mode ? ~bus.b : bus.b;
                        c      <= bus.mode;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    c   <= c_nxt;
                    acc <= acc_nxt;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // c still holds the carry into the MSB on this edge.
                        sum_r  <= acc_nxt;
                        cout_r <= c_nxt;
                        ovf_r  <= c ^ c_nxt;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Bench for serial_addsub (WIDTH = 8): directed arithmetic cases, ignored
//   start, reset abort, and 1000 randomised back-to-back operations compared
//   against an integer-arithmetic reference.
module tb_serial_addsub;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake invariants, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
            check("done_one_cycle", 64'(bus.done & done_prev), 64'd0);
        end
        done_prev <= bus.done;
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic m, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  output logic [WIDTH-1:0] s, output logic co, output logic ov);
        longint ux, uy, sx, sy, ur, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!m) begin
            ur = ux + uy;
            sr = sx + sy;
            co = (ur >= (longint'(1) << WIDTH));
        end else begin
            ur = ux - uy;
            sr = sx - sy;
            co = (ux >= uy);
        end
        s  = ur[WIDTH-1:0];
        ov = (sr > ((longint'(1) << (WIDTH - 1)) - 1)) || (sr < -(longint'(1) << (WIDTH - 1)));
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        while (bus.busy || bus.done) @(negedge clk);
    endtask

    // One operation from IDLE; reports latency (edges after acceptance until
    // done is visible), busy cycles, and whether sum held its old value.
    task automatic do_op(input logic m, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] s, output logic co, output logic ov,
                         output int lat, output int bcyc, output logic held);
        logic [WIDTH-1:0] prev;
        wait_idle();
        prev = bus.sum;
        held = 1'b1;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        lat  = 0;
        bcyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcyc++;
            if (bus.sum !== prev) held = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        s  = bus.sum;
        co = bus.cout;
        ov = bus.overflow;
    endtask

    task automatic directed(input string tag, input logic m, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] es,
                            input logic eco, input logic eov);
        logic [WIDTH-1:0] s;
        logic co, ov, held;
        int lat, bcyc;
        do_op(m, x, y, s, co, ov, lat, bcyc, held);
        check({tag, "_sum"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(co), 64'(eco));
        check({tag, "_ovf"}, 64'(ov), 64'(eov));
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(WIDTH));
        check({tag, "_sum_held"}, 64'(held), 64'd1);
    endtask

    initial begin
        int ndone, to, acc_cyc, prev_acc;
        logic [WIDTH-1:0] ea, eb, es;
        logic em, eco, eov;

        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        rst_n = 1'b1;

        // Directed arithmetic
        directed("add_nocarry", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
        directed("add_carry",   1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        directed("add_ovf",     1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        directed("sub_borrow",  1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        directed("sub_ovf",     1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        directed("sub_equal",   1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);

        // Ignored start during RUN and DONE
        wait_idle();
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        es = '0;
        for (int i = 0; i < 16; i++) begin
            bus.start = (i == 3) || bus.done;
            if (bus.start) begin
                bus.a = 8'hAA;
                bus.b = 8'h01;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                es = bus.sum;
            end
        end
        bus.start = 1'b0;
        check("ignore_done_count", 64'(ndone), 64'd1);
        check("ignore_sum", 64'(es), 64'h02);
        check("ignore_no_queue", 64'(bus.busy), 64'd0);
        directed("add_after_ignore", 1'b0, 8'hAA, 8'h01, 8'hAB, 1'b0, 1'b0);

        // Reset mid-operation
        wait_idle();
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 8'h7F;
        bus.b     = 8'h7F;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        check("abort_ovf", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        directed("add_after_reset", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        // Back-to-back randomised operations with start held high
        wait_idle();
        em = 1'($urandom);
        ea = WIDTH'($urandom);
        eb = WIDTH'($urandom);
        bus.start = 1'b1;
        bus.mode  = em;
        bus.a     = ea;
        bus.b     = eb;
        prev_acc  = 0;
        for (int op = 0; op < 1000; op++) begin
            logic cm;
            logic [WIDTH-1:0] ca, cb;
            to = 0;
            do begin
                @(posedge clk);
                #1;
                to++;
            end while (!bus.busy && to < 30);
            check("b2b_accept_timeout", 64'(to >= 30), 64'd0);
            acc_cyc = cyc;
            if (op > 0) check("b2b_spacing", 64'(acc_cyc - prev_acc), 64'(WIDTH + 2));
            prev_acc = acc_cyc;
            cm = bus.mode;
            ca = bus.a;
            cb = bus.b;
            // Operands change while RUN is in progress; they must not leak in.
            bus.mode = 1'($urandom);
            bus.a    = WIDTH'($urandom);
            bus.b    = WIDTH'($urandom);
            to = 0;
            while (!bus.done && to < 30) begin
                @(posedge clk);
                #1;
                to++;
            end
            check("b2b_done_timeout", 64'(to >= 30), 64'd0);
            model(cm, ca, cb, es, eco, eov);
            check("b2b_sum", 64'(bus.sum), 64'(es));
            check("b2b_cout", 64'(bus.cout), 64'(eco));
            check("b2b_ovf", 64'(bus.overflow), 64'(eov));
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected completion", $time);
        $fatal(1, "global timeout");
    end
endmodule
